clock_period_meter: RTL and testbench

Measures the period and high time of a slow, divided clock signal in units of the system clock, and hands each completed measurement to a consumer over a valid/ready interface. It sits on the receiving side of `clock_divider` outputs, or any slow strobe. Typical uses are checking a divide ratio at run time and flagging a stalled divided clock through a timeout.

---
 rtl/clock_period_meter_pkg.sv | 12 +
 rtl/sync_2ff.sv | 21 ++
 rtl/clock_period_meter.sv | 111 +++++++++++
 tb/tb_clock_period_meter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_period_meter_pkg.sv
// Shared types and parameter defaults for clock_period_meter.
package clock_period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned CNT_W_DEF          = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no backpressure.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_period_meter.sv
// Period/high-time meter for a slow strobe; result 1 cycle after the detected rise (+2 with CLOCK_PERIOD_METER_SYNC_EN).
// One holding register: a capture while meas_valid_o && !meas_ready_i is dropped and flagged on overrun_o.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             meas_ready_i,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic             s;
  logic             p;
  logic             rise;
  logic             capture;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;

`ifdef CLOCK_PERIOD_METER_SYNC_EN
  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (sig_i),
    .q     (s)
  );
`else
  assign s = sig_i;
`endif

  assign rise    = s & ~p;
  assign capture = (state == MEASURE) & rise;

  // Measurement FSM; a rise always wins over the timeout check.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      p         <= 1'b0;
      cnt       <= '0;
      hcnt      <= '0;
      timeout_o <= 1'b0;
    end else begin
      p <= s;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt       <= CNT_ONE;
            hcnt      <= CNT_ONE;
            timeout_o <= 1'b0;
            state     <= MEASURE;
          end else begin
            cnt  <= '0;
            hcnt <= '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt  <= CNT_ONE;
            hcnt <= CNT_ONE;
          end else if (cnt == TMO_VAL) begin
            cnt       <= '0;
            hcnt      <= '0;
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt  <= cnt + CNT_ONE;
            hcnt <= hcnt + CNT_W'(s);
          end
        end
        default: begin
          cnt   <= '0;
          hcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output holding register; a capture that lands on a completing handshake still loads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meas_valid_o <= 1'b0;
      period_o     <= '0;
      high_o       <= '0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (capture && (!meas_valid_o || meas_ready_i)) begin
        period_o     <= cnt;
        high_o       <= hcnt;
        meas_valid_o <= 1'b1;
      end else if (capture) begin
        overrun_o <= 1'b1;
      end else if (meas_valid_o && meas_ready_i) begin
        meas_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter; expected latencies shift by 2 when CLOCK_PERIOD_METER_SYNC_EN is defined.
module tb_clock_period_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 16;
`ifdef CLOCK_PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] high;
  } meas_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig;
  logic             rdy;
  logic             meas_valid_o;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             overrun_o;
  logic             timeout_o;

  meas_t exp_q[$];
  int checks = 0;
  int errors = 0;

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sig_i        (sig),
    .meas_ready_i (rdy),
    .meas_valid_o (meas_valid_o),
    .period_o     (period_o),
    .high_o       (high_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; sig = 1'b0; rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; sig = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (meas_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", meas_valid_o); end
    checks++; if (period_o !== '0) begin errors++; $display("FAIL rst_period got %0d want 0", period_o); end
    checks++; if (high_o !== '0) begin errors++; $display("FAIL rst_high got %0d want 0", high_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_o); end
  endtask

  task automatic test_period4();
    logic sig_n, prev;
    int rises, pulses;
    meas_t e;
    prev = 1'b0; rises = 0; pulses = 0;
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c <= 30 + LAT; c++) begin
      @(negedge clk);
      if (c == 4 + LAT) begin
        checks++; if (meas_valid_o !== 1'b0) begin errors++; $display("FAIL p4_early got %b want 0", meas_valid_o); end
      end
      if (c == 5 + LAT) begin
        checks++; if (meas_valid_o !== 1'b1) begin errors++; $display("FAIL p4_first_valid got %b want 1", meas_valid_o); end
      end
      if (meas_valid_o === 1'b1) pulses++;
      sig_n = (c < 24) && ((c % 4) < 2);
      if (sig_n && !prev) begin
        rises++;
        if (rises > 1) exp_q.push_back({16'd4, 16'd2});
      end
      prev = sig_n; sig = sig_n;
      if (meas_valid_o && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL p4_unexpected got %0d/%0d want none", period_o, high_o); end
        else begin
          e = exp_q.pop_front();
          if ({period_o, high_o} !== e) begin errors++; $display("FAIL p4_data got %0d/%0d want %0d/%0d", period_o, high_o, e.period, e.high); end
        end
      end
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL p4_pulses got %0d want 5", pulses); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL p4_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    logic sig_n, prev;
    int rises;
    meas_t e;
    prev = 1'b0; rises = 0;
    do_reset();
    for (int c = 0; c <= 20 + LAT; c++) begin
      @(negedge clk);
      if (c >= 7 + LAT && c <= 16 + LAT) begin
        checks++;
        if ({meas_valid_o, period_o, high_o} !== {1'b1, 16'd6, 16'd1}) begin
          errors++; $display("FAIL ovr_hold c=%0d got v=%b %0d/%0d want v=1 6/1", c, meas_valid_o, period_o, high_o);
        end
      end
      if (c == 12 + LAT || c == 14 + LAT) begin
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_idle c=%0d got %b want 0", c, overrun_o); end
      end
      if (c == 13 + LAT) begin
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", overrun_o); end
      end
      if (c == 17 + LAT) begin
        checks++; if (meas_valid_o !== 1'b0) begin errors++; $display("FAIL ovr_release got %b want 0", meas_valid_o); end
      end
      sig_n = (c < 18) && ((c % 6) == 0);
      if (sig_n && !prev) begin
        rises++;
        if (rises == 2) exp_q.push_back({16'd6, 16'd1});
      end
      prev = sig_n; sig = sig_n;
      rdy = (c == 16 + LAT);
      if (meas_valid_o && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ovr_unexpected got %0d/%0d want none", period_o, high_o); end
        else begin
          e = exp_q.pop_front();
          if ({period_o, high_o} !== e) begin errors++; $display("FAIL ovr_data got %0d/%0d want %0d/%0d", period_o, high_o, e.period, e.high); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_toggle();
    logic sig_n, prev;
    int rises, pulses;
    meas_t e;
    prev = 1'b0; rises = 0; pulses = 0;
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c <= 20 + LAT; c++) begin
      @(negedge clk);
      if (c == 3 + LAT) begin
        checks++; if (meas_valid_o !== 1'b1) begin errors++; $display("FAIL tog_first_valid got %b want 1", meas_valid_o); end
      end
      if (meas_valid_o === 1'b1) pulses++;
      sig_n = (c < 16) && ((c % 2) == 0);
      if (sig_n && !prev) begin
        rises++;
        if (rises > 1) exp_q.push_back({16'd2, 16'd1});
      end
      prev = sig_n; sig = sig_n;
      if (meas_valid_o && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL tog_unexpected got %0d/%0d want none", period_o, high_o); end
        else begin
          e = exp_q.pop_front();
          if ({period_o, high_o} !== e) begin errors++; $display("FAIL tog_data got %0d/%0d want %0d/%0d", period_o, high_o, e.period, e.high); end
        end
      end
    end
    checks++; if (pulses != 7) begin errors++; $display("FAIL tog_pulses got %0d want 7", pulses); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tog_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    logic sig_n, prev;
    int quiet_pulses;
    meas_t e;
    prev = 1'b0; quiet_pulses = 0;
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c <= 56 + LAT; c++) begin
      @(negedge clk);
      if (c == 24 + LAT) begin
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", timeout_o); end
      end
      if (c == 25 + LAT || c == 40 + LAT) begin
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL tmo_set c=%0d got %b want 1", c, timeout_o); end
      end
      if (c == 41 + LAT) begin
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", timeout_o); end
      end
      if (c == 44 + LAT) begin
        checks++; if (meas_valid_o !== 1'b0) begin errors++; $display("FAIL tmo_resume_early got %b want 0", meas_valid_o); end
      end
      if (c == 45 + LAT) begin
        checks++; if (meas_valid_o !== 1'b1) begin errors++; $display("FAIL tmo_resume_valid got %b want 1", meas_valid_o); end
      end
      if (c >= 10 + LAT && c <= 44 + LAT && meas_valid_o === 1'b1) quiet_pulses++;
      sig_n = ((c < 12) || (c >= 40 && c < 52)) && ((c % 4) < 2);
      if (sig_n && !prev && c != 0 && c != 40) exp_q.push_back({16'd4, 16'd2});
      prev = sig_n; sig = sig_n;
      if (meas_valid_o && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL tmo_unexpected got %0d/%0d want none", period_o, high_o); end
        else begin
          e = exp_q.pop_front();
          if ({period_o, high_o} !== e) begin errors++; $display("FAIL tmo_data got %0d/%0d want %0d/%0d", period_o, high_o, e.period, e.high); end
        end
      end
    end
    checks++; if (quiet_pulses != 0) begin errors++; $display("FAIL tmo_no_capture got %0d want 0", quiet_pulses); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tmo_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic sig_n, prev;
    meas_t e;
    prev = 1'b0;
    do_reset();
    for (int c = 0; c <= 30 + LAT; c++) begin
      @(negedge clk);
      if (c == 9 + LAT) begin
        checks++;
        if ({meas_valid_o, period_o, high_o} !== {1'b1, 16'd8, 16'd2}) begin
          errors++; $display("FAIL rm_before got v=%b %0d/%0d want v=1 8/2", meas_valid_o, period_o, high_o);
        end
      end
      if (c == 11 + LAT) begin
        rst = 1'b0;
        checks++;
        if ({meas_valid_o, period_o, high_o, overrun_o, timeout_o} !== '0) begin
          errors++; $display("FAIL rm_cleared got v=%b %0d/%0d o=%b t=%b want all 0", meas_valid_o, period_o, high_o, overrun_o, timeout_o);
        end
      end
      if (c == 24 + LAT || c == 27 + LAT) begin
        checks++; if (meas_valid_o !== 1'b0) begin errors++; $display("FAIL rm_quiet c=%0d got %b want 0", c, meas_valid_o); end
      end
      if (c == 25 + LAT) begin
        checks++; if (meas_valid_o !== 1'b1) begin errors++; $display("FAIL rm_second_rise got %b want 1", meas_valid_o); end
      end
      if (c == 10 + LAT) begin
        rst = 1'b1;
        exp_q.delete();
      end
      sig_n = (c < 26) && ((c % 8) < 2);
      if (sig_n && !prev && c != 0 && c != 16) exp_q.push_back({16'd8, 16'd2});
      prev = sig_n; sig = sig_n;
      rdy = (c == 26 + LAT);
      if (meas_valid_o && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rm_unexpected got %0d/%0d want none", period_o, high_o); end
        else begin
          e = exp_q.pop_front();
          if ({period_o, high_o} !== e) begin errors++; $display("FAIL rm_data got %0d/%0d want %0d/%0d", period_o, high_o, e.period, e.high); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_leftover got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_period4();
    test_overrun();
    test_toggle();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
